fir_decim_out: RTL and testbench

FIR_DECIM_OUT -- requirements
Module: fir_decim_out

---
 rtl/fir_decim_pkg.sv | 24 ++
 rtl/fir_decim_fifo.sv | 70 +++++++
 rtl/fir_decim_out.sv | 129 ++++++++++++
 tb/tb_fir_decim_out.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: shared widths, ratio limit and saturation bounds for the
// decimating FIR output stage, plus the ratio clamp used when a frame length
// is latched.
package fir_decim_pkg;

   localparam int IN_W_DEF  = 32;               // FIR output width
   localparam int OUT_W_DEF = 16;               // signal bus width
   localparam int ACC_W     = IN_W_DEF + 6;     // 64 full-scale samples fit
   localparam int MAX_RATIO = 64;
   localparam int SAT_MAX   = (1 << (OUT_W_DEF - 1)) - 1;
   localparam int SAT_MIN   = -(1 << (OUT_W_DEF - 1));

   // Map the 7-bit ratio input onto the legal frame length 1..MAX_RATIO.
   function automatic logic [6:0] clamp_ratio(input logic [6:0] r);
      logic [6:0] res;
      res = r;
      if (r == 7'd0)
         res = 7'd1;
      else if (r > 7'(MAX_RATIO))
         res = 7'(MAX_RATIO);
      return res;
   endfunction

endpackage

// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: synchronous D-deep FIFO with a registered head word.
// Latency: a word written into an empty FIFO is on rd_data_o after that edge.
// Backpressure: push when full is ignored unless a pop happens the same cycle.
// Ports: wr_en_i/wr_data_i push side, rd_en_i pop request, rd_data_o head,
//        empty_o/full_o status flags.
module fir_decim_fifo #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = $clog2(D);

   logic [W-1:0]  mem_q [D];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [PW:0]   cnt_q;
   logic [W-1:0]  dout_q;
   logic          push, pop;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == (PW+1)'(D));
   assign pop       = rd_en_i && !empty_o;
   assign push      = wr_en_i && (!full_o || pop);
   assign rd_nxt    = rd_ptr_q + 1'b1;
   assign rd_data_o = dout_q;

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_nxt;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         // The head register tracks the oldest entry: a write into an empty
         // FIFO (or into one that is emptying this cycle) bypasses the array.
         if (empty_o && push)
            dout_q <= wr_data_i;
         else if (pop) begin
            if (cnt_q == (PW+1)'(1)) begin
               if (push)
                  dout_q <= wr_data_i;
            end else
               dout_q <= mem_q[rd_nxt];
         end
      end
   end

endmodule

// File: rtl/fir_decim_out.sv
// fir_decim_out: accumulate-and-dump decimator, round-half-up shift,
// saturation to OUT_W, then a small output FIFO.
// Latency: last sample of a frame at edge k -> out_valid after edge k+2.
// Backpressure: none to the FIR; results hitting a full FIFO are counted.
// Ports: in_data/in_valid from the FIR, ratio/shift control, out_data/
//        out_valid/out_ready consumer side, sat_flag and drop_cnt status.
module fir_decim_out
   import fir_decim_pkg::*;
#(
   parameter int IN_W   = IN_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int FIFO_D = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_valid,
   input  logic        [6:0]       ratio,
   input  logic        [4:0]       shift,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag,
   output logic        [7:0]       drop_cnt
);

   localparam int AW = IN_W + (ACC_W - IN_W_DEF);
   // Output bounds sign-extended to the rounding width.
   localparam logic signed [AW:0] LIM_MAX = {{(AW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [AW:0] LIM_MIN = {{(AW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [AW-1:0]   acc_q, acc_d, sum_q, sum_d, in_ext;
   logic        [6:0]      cnt_q, cnt_d, r_q, r_d, eff_r;
   logic                   arm_q, dump, sum_vld_q;
   logic signed [AW:0]     sum_x, bias, rnd;
   logic signed [OUT_W-1:0] res_q, res_d;
   logic                   res_vld_q, is_sat, sat_q;
   logic        [7:0]      drop_q;
   logic                   fifo_empty, fifo_full, drop;

   assign in_ext = {{(AW-IN_W){in_data[IN_W-1]}}, in_data};
   // Right after reset release the frame length is taken straight from ratio.
   assign eff_r  = arm_q ? clamp_ratio(ratio) : r_q;
   assign dump   = in_valid && (cnt_q == eff_r - 7'd1);
   assign sum_d  = acc_q + in_ext;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      r_d   = eff_r;
      if (in_valid) begin
         if (dump) begin
            acc_d = '0;
            cnt_d = '0;
            r_d   = clamp_ratio(ratio);
         end else begin
            acc_d = sum_d;
            cnt_d = cnt_q + 7'd1;
         end
      end
   end

   // bias = 2^(shift-1), and 0 when shift is 0.
   always_comb begin
      sum_x  = {sum_q[AW-1], sum_q};
      bias   = ({{AW{1'b0}}, 1'b1} << shift) >> 1;
      rnd    = (sum_x + bias) >>> shift;
      is_sat = 1'b0;
      res_d  = rnd[OUT_W-1:0];
      if (rnd > LIM_MAX) begin
         res_d  = LIM_MAX[OUT_W-1:0];
         is_sat = 1'b1;
      end else if (rnd < LIM_MIN) begin
         res_d  = LIM_MIN[OUT_W-1:0];
         is_sat = 1'b1;
      end
   end

   assign drop = res_vld_q && fifo_full && !(out_valid && out_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm_q     <= 1'b1;
         acc_q     <= '0;
         cnt_q     <= '0;
         r_q       <= 7'd1;
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         sat_q     <= 1'b0;
         drop_q    <= '0;
      end else begin
         arm_q     <= 1'b0;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         r_q       <= r_d;
         sum_vld_q <= dump;
         if (dump)
            sum_q <= sum_d;
         res_vld_q <= sum_vld_q;
         if (sum_vld_q)
            res_q <= res_d;
         if (sum_vld_q && is_sat)
            sat_q <= 1'b1;
         if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
      end
   end

   fir_decim_fifo #(
      .W (OUT_W),
      .D (FIFO_D)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (res_vld_q),
      .wr_data_i (res_q),
      .rd_en_i   (out_ready),
      .rd_data_o (out_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign out_valid = !fifo_empty;
   assign sat_flag  = sat_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed vector table plus hand-written frame sequences
// for fir_decim_out with default parameters.
module tb_fir_decim_out;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic signed [31:0] in_data = '0;
   logic               in_valid = 1'b0;
   logic        [6:0]  ratio = 7'd1;
   logic        [4:0]  shift = 5'd0;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               sat_flag;
   logic        [7:0]  drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fir_decim_out dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .ratio     (ratio),
      .shift     (shift),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag),
      .drop_cnt  (drop_cnt)
   );

   typedef struct {
      bit rst_n;
      bit vld;
      int dat;
      int ra;
      int sh;
      bit rdy;
      bit e_vld;
      int e_dat;
      bit e_sat;
      int e_drop;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit r, bit vl, int d, int ra, int sh, bit rdy,
                              bit ev, int ed, bit es, int edr);
      vec_t x;
      x.rst_n = r;  x.vld = vl;   x.dat = d;    x.ra = ra;  x.sh = sh;
      x.rdy = rdy;  x.e_vld = ev; x.e_dat = ed; x.e_sat = es; x.e_drop = edr;
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int ra, input int sh);
      rst = 1'b0; ratio = 7'(ra); shift = 5'(sh);
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      step();
      chk("rst.vld",  int'(out_valid), 0);
      chk("rst.dat",  int'(out_data),  0);
      chk("rst.sat",  int'(sat_flag),  0);
      chk("rst.drop", int'(drop_cnt),  0);
      rst = 1'b1;
   endtask

   // n samples of d, then out_valid must rise exactly two edges later.
   task automatic run_frame(input string nm, input int n, input int d,
                            input int exp, input bit es);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_data = d;
         step();
         if (i == n - 1 || i == 0)
            chk($sformatf("%s.early%0d", nm, i), int'(out_valid), 0);
      end
      in_valid = 1'b0;
      step();
      chk({nm, ".gap"}, int'(out_valid), 0);
      step();
      chk({nm, ".vld"}, int'(out_valid), 1);
      chk({nm, ".dat"}, int'(out_data),  exp);
      chk({nm, ".sat"}, int'(sat_flag),  int'(es));
   endtask

   initial begin
      @(negedge clk);

      // R=4, shift=0, 100 per cycle
      tbl.push_back(v(0,0,0,4,0,1, 0,0,0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(v(1,1,100,4,0,1, 0,0,0,0));
      tbl.push_back(v(1,1,100,4,0,1, 1,400,0,0));
      tbl.push_back(v(1,1,100,4,0,1, 0,0,0,0));
      tbl.push_back(v(1,1,100,4,0,1, 0,0,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   0,0,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   1,400,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   0,0,0,0));
      // R=1, shift=2: 7 -> 2, -7 -> -2
      tbl.push_back(v(0,0,0,1,2,1,   0,0,0,0));
      tbl.push_back(v(1,1,7,1,2,1,   0,0,0,0));
      tbl.push_back(v(1,1,-7,1,2,1,  0,0,0,0));
      tbl.push_back(v(1,0,0,1,2,1,   1,2,0,0));
      tbl.push_back(v(1,0,0,1,2,1,   1,-2,0,0));
      tbl.push_back(v(1,0,0,1,2,1,   0,0,0,0));
      // R=1, consumer stalled: 4 queued, 2 dropped, then drained in order
      tbl.push_back(v(0,0,0,1,0,0,   0,0,0,0));
      tbl.push_back(v(1,1,1,1,0,0,   0,0,0,0));
      tbl.push_back(v(1,1,2,1,0,0,   0,0,0,0));
      tbl.push_back(v(1,1,3,1,0,0,   1,1,0,0));
      tbl.push_back(v(1,1,4,1,0,0,   1,1,0,0));
      tbl.push_back(v(1,1,5,1,0,0,   1,1,0,0));
      tbl.push_back(v(1,1,6,1,0,0,   1,1,0,0));
      tbl.push_back(v(1,0,0,1,0,0,   1,1,0,1));
      tbl.push_back(v(1,0,0,1,0,0,   1,1,0,2));
      tbl.push_back(v(1,0,0,1,0,1,   1,2,0,2));
      tbl.push_back(v(1,0,0,1,0,1,   1,3,0,2));
      tbl.push_back(v(1,0,0,1,0,1,   1,4,0,2));
      tbl.push_back(v(1,0,0,1,0,1,   0,0,0,2));
      // reset clears drop count; partial frame discarded by mid-frame reset
      tbl.push_back(v(0,0,0,4,0,1,   0,0,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(v(1,1,5,4,0,1, 0,0,0,0));
      tbl.push_back(v(0,0,0,4,0,1,   0,0,0,0));
      for (int i = 0; i < 4; i++) tbl.push_back(v(1,1,5,4,0,1, 0,0,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   0,0,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   1,20,0,0));
      tbl.push_back(v(1,0,0,4,0,1,   0,0,0,0));
      // R=4 changed to 2 after the 2nd sample: 40, 20, 20
      tbl.push_back(v(0,0,0,4,0,1,   0,0,0,0));
      tbl.push_back(v(1,1,10,4,0,1,  0,0,0,0));
      tbl.push_back(v(1,1,10,4,0,1,  0,0,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(v(1,1,10,2,0,1, 0,0,0,0));
      tbl.push_back(v(1,1,10,2,0,1,  1,40,0,0));
      tbl.push_back(v(1,1,10,2,0,1,  0,0,0,0));
      tbl.push_back(v(1,1,10,2,0,1,  1,20,0,0));
      tbl.push_back(v(1,0,0,2,0,1,   0,0,0,0));
      tbl.push_back(v(1,0,0,2,0,1,   1,20,0,0));
      tbl.push_back(v(1,0,0,2,0,1,   0,0,0,0));

      foreach (tbl[i]) begin
         rst       = tbl[i].rst_n;
         in_valid  = tbl[i].vld;
         in_data   = tbl[i].dat;
         ratio     = 7'(tbl[i].ra);
         shift     = 5'(tbl[i].sh);
         out_ready = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d.vld", i), int'(out_valid), int'(tbl[i].e_vld));
         if (tbl[i].e_vld || !tbl[i].rst_n)
            chk($sformatf("vec%0d.dat", i), int'(out_data), tbl[i].e_dat);
         chk($sformatf("vec%0d.sat", i), int'(sat_flag), int'(tbl[i].e_sat));
         chk($sformatf("vec%0d.drop", i), int'(drop_cnt), tbl[i].e_drop);
      end

      // R=64: positive then negative saturation, sticky flag
      do_reset(64, 0);
      run_frame("sat_pos", 64, 1000, 32767, 1'b1);
      run_frame("sat_neg", 64, -1000, -32768, 1'b1);
      // ratio above 64 acts as 64; reset cleared the sticky flag
      do_reset(127, 0);
      run_frame("ratio127", 64, 500, 32000, 1'b0);
      // ratio 0 acts as 1
      do_reset(0, 0);
      run_frame("ratio0", 1, -3, -3, 1'b0);
      // shift=1 round half up: 3 -> 2, -3 -> -1
      do_reset(1, 1);
      run_frame("rnd_pos", 1, 3, 2, 1'b0);
      run_frame("rnd_neg", 1, -3, -1, 1'b0);

      // drop counter saturates at 255
      do_reset(1, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 270; i++) begin
         in_valid = 1'b1; in_data = i + 1;
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("drop_sat.cnt", int'(drop_cnt),  255);
      chk("drop_sat.vld", int'(out_valid), 1);
      chk("drop_sat.dat", int'(out_data),  1);
      out_ready = 1'b1;
      step();
      chk("drop_sat.next", int'(out_data), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
